wb_arbiter: RTL
===============

# wb_arbiter

Parametrised writeback arbiter replacing the single-source writeback decode in the CPU. It accepts completed results from `NUM_CH` producers (integer pipe, load unit, multi-cycle divide/FPU, etc.), each through a valid/ready handshake and a per-channel FIFO. It decodes each result's 5-bit op into an integer-RF write, an FP-RF write, or no write. Each cycle it grants at most one integer write and one FP write using independent round-robin arbitration.

## Interface
Parameters:
- `NUM_CH`, 3: number of producer channels (2..8).
- `DATA_W`, 32: result width.
- `FIFO_DEPTH`, 2: entries per channel FIFO (power of two, ≥2).

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ch_valid`  in  NUM_CH  per-channel result valid.
- `ch_ready`  out  NUM_CH  per-channel FIFO not full.
- `ch_op`  in  NUM_CH*5  per-channel op (shared `OP_*` encoding); channel k in bits [5k+4:5k].
- `ch_rd`  in  NUM_CH*5  destination register index.
- `ch_data`  in  NUM_CH*DATA_W  result data.
- `rf_we`  out  1  integer register-file write enable.
- `rf_waddr`  out  5  integer write address.
- `rf_wdata`  out  DATA_W  integer write data.
- `frf_we`  out  1  FP register-file write enable.
- `frf_waddr`  out  5  FP write address.
- `frf_wdata`  out  DATA_W  FP write data.
- `idle`  out  1  all FIFOs empty and no write in flight.

## Operation
- Push: channel k pushes when `ch_valid[k] && ch_ready[k]`. `ch_ready[k] = !full[k]` depends only on the count, not on a same-cycle pop. A full FIFO therefore refuses a push even if it pops that cycle.
- Decode, on the FIFO head:
  - INT class: `OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_I_LOAD, OP_I_ARITH, OP_RM_TYPE, OP_CSR`.
  - FP class: `OP_FTYPE, OP_FLW`.
  - NONE class: everything else.
- Discard: a head of class NONE, or INT with rd==0, pops in the cycle it reaches the head. It needs no grant and produces no write. FP writes to f0 are legal.
- Arbitration, independent for the INT port and the FP port:
  - Requesters are the channels whose non-empty head is of that class.
  - Priority starts at `ptr`, then `ptr+1`, … mod NUM_CH.
  - The winner pops. The port's `ptr` becomes winner+1 mod NUM_CH.
  - If there is no winner, `ptr` holds.
  - One channel can win at most one port per cycle because it has only one head.
- Output registers: granted rd/data are registered into `rf_*`/`frf_*`. `*_we` is high for exactly one cycle per grant.
- Order: entries within one channel write back in push order. No ordering is guaranteed across channels.
- `idle = (all counts == 0) && !rf_we && !frf_we`.
- Reset:
  - All FIFO counts and read/write pointers go to 0, which drops any in-flight entries.
  - Both `ptr` go to 0.
  - `rf_we`, `frf_we` = 0; `rf_waddr`, `frf_waddr` = 0; `rf_wdata`, `frf_wdata` = 0.
  - `ch_ready` = all ones and `idle` = 1 in the cycle after `rst` deasserts.

## Timing
- Push in cycle N puts the entry at the head in N+1. The earliest grant is N+1, and the earliest `*_we` is N+2.
- A discarded entry frees its slot in N+1. No write follows it.
- Steady state: each port sustains one write per cycle. A channel sustains one push per cycle only while its FIFO is not full.
- A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Pointer wrap: FIFO pointers wrap modulo FIFO_DEPTH. The round-robin pointer wraps from NUM_CH-1 to 0.
- `rst` asserted mid-stream: the next edge forces the reset values above. Entries pushed in that cycle are dropped.

## Test plan
- Reset: hold `rst` 2 cycles with all `ch_valid`=1. Require `rf_we`=`frf_we`=0, `idle`=1 and `ch_ready`=3'b111 afterwards, and no write for the dropped inputs.
- Single INT: ch0 pushes op=`OP_I_ARITH`, rd=5, data=0x1234 in cycle 0. Require `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234 in cycle 2, exactly one cycle, and `frf_we`=0 throughout.
- Concurrent ports: ch0 pushes `OP_I_LOAD` rd=3, and ch1 pushes `OP_FLW` rd=3 data=0x3F800000, in the same cycle. Require `rf_we` and `frf_we` both high two cycles later.
- Round-robin: ch0, ch1 and ch2 each push 4 `OP_I_ARITH` entries back to back. Require integer writes in channel order 0,1,2,0,1,2,… with no channel granted twice while another has a head pending.
- Discards:
  - ch2 pushes `OP_I_ARITH` rd=0. Require no `rf_we`.
  - ch2 pushes op=`OP_STORE`. Require no write.
  - ch2 pushes `OP_FTYPE` rd=0. Require `frf_we` with `frf_waddr`=0.
- Backpressure: with FIFO_DEPTH=2, ch0 pushes 3 INT entries in consecutive cycles while ch1 keeps the INT port contested. Require `ch_ready[0]`=0 when the count is 2, the third entry held until accepted, and all 3 written in push order.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Producer-to-writeback bundle for wb_arbiter: per-channel result handshake
// plus the integer and FP register-file write ports.
interface wb_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH-1:0]        ch_ready;
    logic [NUM_CH*5-1:0]      ch_op;
    logic [NUM_CH*5-1:0]      ch_rd;
    logic [NUM_CH*DATA_W-1:0] ch_data;

    logic                     rf_we;
    logic [4:0]               rf_waddr;
    logic [DATA_W-1:0]        rf_wdata;
    logic                     frf_we;
    logic [4:0]               frf_waddr;
    logic [DATA_W-1:0]        frf_wdata;
    logic                     idle;

    modport master (
        output ch_valid, ch_op, ch_rd, ch_data,
        input  ch_ready, rf_we, rf_waddr, rf_wdata,
        input  frf_we, frf_waddr, frf_wdata, idle
    );

    modport slave (
        input  ch_valid, ch_op, ch_rd, ch_data,
        output ch_ready, rf_we, rf_waddr, rf_wdata,
        output frf_we, frf_waddr, frf_wdata, idle
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-channel result FIFOs, op decode, and independent
// round-robin grants for one integer and one FP register-file write per cycle.
module wb_arb_fifo #(
    parameter int W     = 42,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];
    // Fullness comes from the registered count only: a full FIFO refuses a push even while popping.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end
endmodule

module wb_arbiter #(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_CH);

    localparam logic [4:0] OP_LUI     = 5'b01101;
    localparam logic [4:0] OP_AUIPC   = 5'b00101;
    localparam logic [4:0] OP_JAL     = 5'b11011;
    localparam logic [4:0] OP_JALR    = 5'b11001;
    localparam logic [4:0] OP_I_LOAD  = 5'b00000;
    localparam logic [4:0] OP_I_ARITH = 5'b00100;
    localparam logic [4:0] OP_RM_TYPE = 5'b01100;
    localparam logic [4:0] OP_CSR     = 5'b11100;
    localparam logic [4:0] OP_FTYPE   = 5'b10100;
    localparam logic [4:0] OP_FLW     = 5'b00001;

    typedef struct packed {
        logic [4:0]        op;
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } wb_ent_t;

    typedef enum logic [1:0] {CLS_NONE, CLS_INT, CLS_FP} wb_cls_e;

    function automatic wb_cls_e op_class(input logic [4:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_I_LOAD, OP_I_ARITH, OP_RM_TYPE, OP_CSR: return CLS_INT;
            OP_FTYPE, OP_FLW:                          return CLS_FP;
            default:                                   return CLS_NONE;
        endcase
    endfunction

    // Returns {found, index} of the first requester at or after ptr, wrapping at NUM_CH.
    function automatic logic [PW:0] rr_pick(input logic [NUM_CH-1:0] req,
                                            input logic [PW-1:0]     ptr);
        logic [PW:0] res;
        int          c;
        res = '0;
        c   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = int'(ptr) + i;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (!res[PW] && req[c]) res = {1'b1, PW'(c)};
        end
        return res;
    endfunction

    wb_ent_t           head [NUM_CH];
    wb_cls_e           cls  [NUM_CH];
    logic [NUM_CH-1:0] empty, full, push, pop;
    logic [NUM_CH-1:0] int_req, fp_req, discard, int_gnt, fp_gnt;
    logic [PW:0]       int_pick, fp_pick;

    logic [PW-1:0]     iptr_q, iptr_d, fptr_q, fptr_d;
    logic              rf_we_q, rf_we_d, frf_we_q, frf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d, frf_waddr_q, frf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d, frf_wdata_q, frf_wdata_d;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        wb_ent_t                 din;
        logic [$bits(wb_ent_t)-1:0] head_vec;

        assign din     = {bus.ch_op[5*k +: 5], bus.ch_rd[5*k +: 5], bus.ch_data[DATA_W*k +: DATA_W]};
        assign push[k] = bus.ch_valid[k] && !full[k];

        wb_arb_fifo #(
            .W     ($bits(wb_ent_t)),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[k]),
            .pop_i   (pop[k]),
            .din_i   (din),
            .head_o  (head_vec),
            .empty_o (empty[k]),
            .full_o  (full[k])
        );

        assign head[k]    = wb_ent_t'(head_vec);
        assign cls[k]     = op_class(head[k].op);
        assign int_req[k] = !empty[k] && (cls[k] == CLS_INT) && (head[k].rd != 5'd0);
        assign fp_req[k]  = !empty[k] && (cls[k] == CLS_FP);
        // Non-writing heads and x0 integer writes retire on their own, no grant needed.
        assign discard[k] = !empty[k] && ((cls[k] == CLS_NONE) ||
                                          ((cls[k] == CLS_INT) && (head[k].rd == 5'd0)));
    end

    always_comb begin
        int_pick    = rr_pick(int_req, iptr_q);
        fp_pick     = rr_pick(fp_req, fptr_q);
        int_gnt     = int_pick[PW] ? (NUM_CH'(1) << int_pick[PW-1:0]) : '0;
        fp_gnt      = fp_pick[PW]  ? (NUM_CH'(1) << fp_pick[PW-1:0])  : '0;
        pop         = discard | int_gnt | fp_gnt;

        rf_we_d     = int_pick[PW];
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        frf_we_d    = fp_pick[PW];
        frf_waddr_d = frf_waddr_q;
        frf_wdata_d = frf_wdata_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int_gnt[k]) begin
                rf_waddr_d = head[k].rd;
                rf_wdata_d = head[k].data;
            end
            if (fp_gnt[k]) begin
                frf_waddr_d = head[k].rd;
                frf_wdata_d = head[k].data;
            end
        end

        iptr_d = iptr_q;
        if (int_pick[PW])
            iptr_d = (int_pick[PW-1:0] == PW'(NUM_CH-1)) ? '0 : int_pick[PW-1:0] + 1'b1;
        fptr_d = fptr_q;
        if (fp_pick[PW])
            fptr_d = (fp_pick[PW-1:0] == PW'(NUM_CH-1)) ? '0 : fp_pick[PW-1:0] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iptr_q      <= '0;
            fptr_q      <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            frf_we_q    <= 1'b0;
            frf_waddr_q <= '0;
            frf_wdata_q <= '0;
        end else begin
            iptr_q      <= iptr_d;
            fptr_q      <= fptr_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            frf_we_q    <= frf_we_d;
            frf_waddr_q <= frf_waddr_d;
            frf_wdata_q <= frf_wdata_d;
        end
    end

    assign bus.ch_ready  = ~full;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.frf_we    = frf_we_q;
    assign bus.frf_waddr = frf_waddr_q;
    assign bus.frf_wdata = frf_wdata_q;
    assign bus.idle      = (&empty) && !rf_we_q && !frf_we_q;
endmodule
